// File: rtl/imem_loadable.sv
// Loadable, registered-read instruction memory for the pipelined MIPS core.
// A word-serial valid/ready port fills the array; fetches are served only once a program is loaded.
module imem_loadable #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned PC_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [IDX_W:0]        load_len,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  load_err,
  input  logic [PC_WIDTH-1:0]   fetch_pc,
  input  logic                  fetch_stall,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  fetch_valid,
  output logic                  fetch_fault
);

  localparam int unsigned CW = IDX_W + 1;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t                state;
  logic [CW-1:0]         len;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  xfer;
  logic                  last;
  logic                  fault;
  logic                  clipped;
  logic [IDX_W-1:0]      index;
  logic [PC_WIDTH-1:0]   word_addr;

  assign xfer      = load_valid && load_ready;
  assign last      = xfer && (count == len - CW'(1));
  assign clipped   = load_len > CW'(DEPTH);
  assign word_addr = fetch_pc >> 2;
  assign index     = fetch_pc[IDX_W+1:2];
  assign fault     = (fetch_pc[1:0] != 2'b00) || (word_addr >= PC_WIDTH'(DEPTH));

  // Array is deliberately not reset so a partial load survives a reset.
  always_ff @(posedge clk) begin
    if (xfer) mem[count[IDX_W-1:0]] <= load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      len         <= '0;
      count       <= '0;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      instruction <= NOP_WORD;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      load_done <= 1'b0;

      case (state)
        EMPTY, READY: begin
          if (load_start) begin
            count    <= '0;
            load_err <= clipped;
            len      <= clipped ? CW'(DEPTH) : load_len;
            if (load_len == '0) begin
              state      <= READY;
              load_done  <= 1'b1;
              load_ready <= 1'b0;
            end else begin
              state      <= LOAD;
              load_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            count <= count + CW'(1);
            if (last) begin
              state      <= READY;
              load_ready <= 1'b0;
              load_done  <= 1'b1;
            end
          end
        end
        default: begin
          state      <= EMPTY;
          load_ready <= 1'b0;
        end
      endcase

      // Fetch path sees the pre-edge state, so the final load edge still returns NOP.
      if (!fetch_stall) begin
        if (state == READY && !fault) begin
          instruction <= mem[index];
          fetch_valid <= 1'b1;
          fetch_fault <= 1'b0;
        end else if (state == READY) begin
          instruction <= NOP_WORD;
          fetch_valid <= 1'b0;
          fetch_fault <= 1'b1;
        end else begin
          instruction <= NOP_WORD;
          fetch_valid <= 1'b0;
          fetch_fault <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: load, fetch, faults, stall, clipping, zero-length load, reset mid-load.
module tb_imem_loadable;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned PC_WIDTH = 32;
  localparam int unsigned IDX_W = 6;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  load_start;
  logic [IDX_W:0]        load_len;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_ready;
  logic                  load_done;
  logic                  load_err;
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  fetch_stall;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  fetch_valid;
  logic                  fetch_fault;

  int checks = 0;
  int failures = 0;

  imem_loadable #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH(DEPTH),
    .PC_WIDTH(PC_WIDTH),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_start(load_start),
    .load_len(load_len),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .load_done(load_done),
    .load_err(load_err),
    .fetch_pc(fetch_pc),
    .fetch_stall(fetch_stall),
    .instruction(instruction),
    .fetch_valid(fetch_valid),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] instr, input logic valid, input logic flt);
    check({tag, "_instr"}, instruction, instr);
    check({tag, "_valid"}, 32'(fetch_valid), 32'(valid));
    check({tag, "_fault"}, 32'(fetch_fault), 32'(flt));
  endtask

  initial begin
    logic [31:0] prog [3];
    int accepted;
    bit done_seen;

    prog[0] = 32'h2008_0020;
    prog[1] = 32'h2009_0037;
    prog[2] = 32'h0109_8024;

    reset = 1'b1;
    load_start = 1'b0;
    load_len = '0;
    load_valid = 1'b0;
    load_data = '0;
    fetch_pc = '0;
    fetch_stall = 1'b0;

    // Reset values
    tick();
    tick();
    check_fetch("rst", 32'h0, 1'b0, 1'b0);
    check("rst_ready", 32'(load_ready), 32'h0);
    check("rst_done", 32'(load_done), 32'h0);
    check("rst_err", 32'(load_err), 32'h0);
    reset = 1'b0;
    tick();
    check_fetch("empty_fetch", 32'h0, 1'b0, 1'b0);
    check("empty_ready", 32'(load_ready), 32'h0);

    // Three-word load with valid gaps
    load_start = 1'b1;
    load_len = 7'd3;
    tick();
    load_start = 1'b0;
    check("load3_ready0", 32'(load_ready), 32'h1);
    check("load3_err", 32'(load_err), 32'h0);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b0;
      tick();
      check("load3_gap_ready", 32'(load_ready), 32'h1);
      check("load3_gap_done", 32'(load_done), 32'h0);
      check_fetch("load3_fetch", 32'h0, 1'b0, 1'b0);
      load_valid = 1'b1;
      load_data = prog[i];
      tick();
      check("load3_done", 32'(load_done), (i == 2) ? 32'h1 : 32'h0);
      check("load3_ready", 32'(load_ready), (i == 2) ? 32'h0 : 32'h1);
    end
    load_valid = 1'b0;
    tick();
    check("load3_done_once", 32'(load_done), 32'h0);

    // Consecutive fetches
    for (int i = 0; i < 3; i++) begin
      fetch_pc = 32'(i * 4);
      tick();
      check_fetch("fetch_seq", prog[i], 1'b1, 1'b0);
    end

    // Misaligned and out-of-range fetches
    fetch_pc = 32'h6;
    tick();
    check_fetch("misalign", 32'h0, 1'b0, 1'b1);
    fetch_pc = 32'(4 * DEPTH);
    tick();
    check_fetch("oor", 32'h0, 1'b0, 1'b1);
    fetch_pc = 32'h4;
    tick();
    check_fetch("after_fault", prog[1], 1'b1, 1'b0);

    // Stall holds output while the PC moves
    fetch_stall = 1'b1;
    fetch_pc = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fetch("stall_hold", prog[1], 1'b1, 1'b0);
    end
    fetch_stall = 1'b0;
    tick();
    check_fetch("stall_release", prog[2], 1'b1, 1'b0);

    // Clipped load: DEPTH+5 requested, DEPTH accepted
    load_start = 1'b1;
    load_len = 7'(DEPTH + 5);
    tick();
    load_start = 1'b0;
    check("clip_err", 32'(load_err), 32'h1);
    check("clip_ready", 32'(load_ready), 32'h1);
    accepted = 0;
    done_seen = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 100 && !done_seen; i++) begin
      if (load_ready) begin
        load_data = 32'hC000_0000 + 32'(accepted);
        accepted++;
      end
      tick();
      if (load_done) done_seen = 1'b1;
    end
    load_valid = 1'b0;
    check("clip_done_seen", 32'(done_seen), 32'h1);
    check("clip_count", 32'(accepted), 32'(DEPTH));
    check("clip_ready_end", 32'(load_ready), 32'h0);
    fetch_pc = 32'(4 * (DEPTH - 1));
    tick();
    check("clip_done_once", 32'(load_done), 32'h0);
    check_fetch("clip_last", 32'hC000_003F, 1'b1, 1'b0);
    fetch_pc = 32'h0;
    tick();
    check_fetch("clip_first", 32'hC000_0000, 1'b1, 1'b0);

    // Zero-length load keeps old contents
    load_start = 1'b1;
    load_len = 7'd0;
    tick();
    load_start = 1'b0;
    check("zero_done", 32'(load_done), 32'h1);
    check("zero_err", 32'(load_err), 32'h0);
    check("zero_ready", 32'(load_ready), 32'h0);
    fetch_pc = 32'h8;
    tick();
    check("zero_done_once", 32'(load_done), 32'h0);
    check_fetch("zero_old", 32'hC000_0002, 1'b1, 1'b0);

    // Asynchronous reset after two of four words
    load_start = 1'b1;
    load_len = 7'd4;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_data = 32'hD000_0000 + 32'(i);
      tick();
    end
    check("midrst_ready_pre", 32'(load_ready), 32'h1);
    load_data = 32'hD000_0002;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(load_ready), 32'h0);
    check("midrst_done", 32'(load_done), 32'h0);
    check("midrst_err", 32'(load_err), 32'h0);
    check_fetch("midrst", 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    load_valid = 1'b0;
    fetch_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_done", 32'(load_done), 32'h0);
      check("postrst_ready", 32'(load_ready), 32'h0);
      check_fetch("postrst", 32'h0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised, synchronous instruction memory for the pipelined MIPS core.
- Successor to the fixed, combinational instruction ROM: depth and width are configurable, and the read is registered with 1-cycle latency and IF-stall hold.
- A word-serial program-load port with a valid/ready handshake fills the memory at run time.
- Fetches that are misaligned, out of range, or made while no program is loaded return a NOP and raise a fault flag.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits.
- DEPTH, 64, number of words; any value from 2 upward.
- PC_WIDTH, 32, byte-address width of fetch_pc.
- NOP_WORD, 32'h00000000, word driven on every invalid or faulted fetch.
- IDX_W, $clog2(DEPTH), word-index width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  1-cycle pulse; begins a program load.
- load_len  in  IDX_W+1  number of words to load; sampled on load_start.
- load_valid  in  1  load_data holds a valid word.
- load_data  in  DATA_WIDTH  word to write.
- load_ready  out  1  block accepts a word this cycle.
- load_done  out  1  1-cycle pulse when the last word has been written.
- load_err  out  1  sticky flag: load_len was clipped; cleared by the next load_start.
- fetch_pc  in  PC_WIDTH  byte address to fetch.
- fetch_stall  in  1  hold the current instruction output.
- instruction  out  DATA_WIDTH  registered instruction.
- fetch_valid  out  1  instruction holds a real fetched word.
- fetch_fault  out  1  the fetch that produced instruction was invalid.

Behaviour:
- Reset (asynchronous, active-high) drives:
  - state=EMPTY; load_ready=0, load_done=0, load_err=0;
  - instruction=NOP_WORD, fetch_valid=0, fetch_fault=0;
  - word counter=0.
  - Memory array contents are not cleared.
- States: EMPTY, LOAD, READY.
  - EMPTY -> LOAD on load_start.
  - LOAD -> READY when the last word is accepted.
  - READY -> LOAD on load_start.
  - A load_start pulse while in LOAD is ignored.
- Load start:
  - On load_start, latch len = min(load_len, DEPTH) and clear the counter.
  - load_err <= 1 if load_len > DEPTH, else 0.
  - If load_len == 0: go to READY immediately, pulse load_done next cycle, write nothing. Earlier contents beyond the current load remain readable.
- LOAD handshake:
  - load_ready = 1 in LOAD only.
  - A word transfers when load_valid && load_ready: mem[counter] <= load_data, then counter++.
  - The transfer of word len-1 registers load_done=1 for one cycle, moves to READY and deasserts load_ready that same edge.
  - load_valid while load_ready=0 is ignored; no write occurs.
- Fetch (index = fetch_pc[IDX_W+1:2]):
  - On each rising edge with fetch_stall=0 the output registers update.
  - fault = (fetch_pc[1:0] != 0) || (fetch_pc >> 2) >= DEPTH.
  - In READY with no fault: instruction <= mem[index], fetch_valid <= 1, fetch_fault <= 0.
  - In READY with a fault: instruction <= NOP_WORD, fetch_valid <= 0, fetch_fault <= 1.
  - In EMPTY or LOAD: instruction <= NOP_WORD, fetch_valid <= 0, fetch_fault <= 0. The core must stall.
- fetch_stall=1: all three fetch outputs hold their values. A stall has no effect on the load path.
- Read latency: 1 cycle from fetch_pc to instruction.
- Same-edge collisions:
  - The last load word and a fetch on the same edge: the fetch still sees state LOAD and returns NOP. The next fetch returns the new contents.
  - A write to address A and a fetch of A on the same edge cannot both happen, because fetches are not served in LOAD.
- Reset mid-load: the load aborts, state goes to EMPTY, partially written words stay in the array, and load_done is not pulsed.

Test Plan:
- Reset, then fetch_pc=0 -> instruction=0, fetch_valid=0, fetch_fault=0; load_ready=0.
- load_start with load_len=3, then words 0x20080020, 0x20090037, 0x01098024 with load_valid gaps -> load_ready=1 for the whole of LOAD; load_done pulses exactly once, on the cycle after the 3rd transfer; fetch_pc 0, 4, 8 on consecutive cycles -> those words one cycle later, fetch_valid=1.
- In READY, fetch_pc=0x6 -> NOP, fault=1. fetch_pc=4*DEPTH -> NOP, fault=1. fetch_pc=4 on the next cycle -> 0x20090037, fault=0.
- Fetch 0x4, hold fetch_stall=1 for 3 cycles while fetch_pc changes to 0x8 -> instruction stays 0x20090037; after release -> 0x01098024.
- load_len=DEPTH+5 -> load_err=1; exactly DEPTH words accepted before load_done. load_start with load_len=0 -> load_done next cycle, load_err=0, old contents fetchable.
- Assert reset after 2 of 4 load words -> all outputs return to reset values asynchronously; state EMPTY; fetches return NOP; no load_done.
